act_skew_buffer: RTL and testbench



---
 rtl/act_skew_buffer.sv | 126 ++++++++++++
 tb/tb_act_skew_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_buffer.sv
// Diagonal skew buffer feeding the PE array west edge: lane k is delayed k+1
// cycles, idle slots are zero-filled, and a done pulse marks the end of a drain.
module act_skew_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int PE_SIZE    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [PE_SIZE*DATA_WIDTH-1:0] act_i,
  input  logic                          act_valid_i,
  output logic [PE_SIZE*DATA_WIDTH-1:0] act_o,
  output logic [PE_SIZE-1:0]            act_valid_o,
  output logic                          busy_o,
  output logic                          drain_done_o,
  output logic [CNT_WIDTH-1:0]          vec_cnt_o
);

  localparam int DCW = $clog2(PE_SIZE + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FEED  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic                 accept;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] vec_cnt_q, vec_cnt_d;
  logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
  logic                 drain_done_q, drain_done_d;

  assign accept = en & act_valid_i;

  // Triangular shift array: lane k owns k+1 stages, so its output lags lane 0 by k cycles.
  for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] dat_q [k+1];
    logic [k:0]            vld_q;
    logic [DATA_WIDTH-1:0] lane_in;

    assign lane_in = accept ? act_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i <= k; i++) dat_q[i] <= '0;
        vld_q <= '0;
      end else if (en) begin
        for (int i = k; i > 0; i--) begin
          dat_q[i] <= dat_q[i-1];
          vld_q[i] <= vld_q[i-1];
        end
        dat_q[0] <= lane_in;
        vld_q[0] <= accept;
      end
    end

    assign act_o[k*DATA_WIDTH +: DATA_WIDTH] = dat_q[k];
    assign act_valid_o[k]                    = vld_q[k];
  end

  // Drain lasts until the last accepted vector reaches the final lane; an accept restarts FEED.
  always_comb begin
    state_d      = state_q;
    vec_cnt_d    = vec_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    drain_done_d = drain_done_q;
    if (en) begin
      drain_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d   = FEED;
            vec_cnt_d = CNT_WIDTH'(1);
          end
        end
        FEED: begin
          if (accept) begin
            vec_cnt_d = (vec_cnt_q == '1) ? vec_cnt_q : vec_cnt_q + 1'b1;
          end else if (PE_SIZE <= 2) begin
            state_d      = IDLE;
            drain_done_d = 1'b1;
          end else begin
            state_d     = DRAIN;
            drain_cnt_d = DCW'(PE_SIZE - 1);
          end
        end
        DRAIN: begin
          if (accept) begin
            state_d     = FEED;
            vec_cnt_d   = (vec_cnt_q == '1) ? vec_cnt_q : vec_cnt_q + 1'b1;
            drain_cnt_d = '0;
          end else if (drain_cnt_q <= DCW'(2)) begin
            state_d      = IDLE;
            drain_cnt_d  = '0;
            drain_done_d = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          drain_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_cnt_q    <= vec_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      drain_done_q <= drain_done_d;
    end
  end

  // A pulse landing just before a stall stays latched and reappears once en returns.
  assign drain_done_o = drain_done_q & en;
  assign busy_o       = (state_q != IDLE);
  assign vec_cnt_o    = vec_cnt_q;

endmodule

// File: tb/tb_act_skew_buffer.sv
// Directed bench for act_skew_buffer: a vector table for the single-vector case
// plus hand sequences for bursts, gaps, stalls and asynchronous reset.
module tb_act_skew_buffer;

  localparam int DW = 8;
  localparam int PS = 16;
  localparam int CW = 16;
  localparam int AW = DW * PS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          act_valid_i = 1'b0;
  logic [AW-1:0] act_i = '0;
  logic [AW-1:0] act_o;
  logic [PS-1:0] act_valid_o;
  logic          busy_o;
  logic          drain_done_o;
  logic [CW-1:0] vec_cnt_o;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] histD [$];
  logic          histV [$];

  typedef struct {
    logic          e;
    logic          v;
    logic [AW-1:0] d;
    logic [AW-1:0] expAct;
    logic [PS-1:0] expVld;
    logic          expBusy;
    logic          expDone;
    logic [CW-1:0] expCnt;
  } vec_t;

  vec_t tbl [18];

  always #5 clk = ~clk;

  act_skew_buffer #(.DATA_WIDTH(DW), .PE_SIZE(PS), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .act_i        (act_i),
    .act_valid_i  (act_valid_i),
    .act_o        (act_o),
    .act_valid_o  (act_valid_o),
    .busy_o       (busy_o),
    .drain_done_o (drain_done_o),
    .vec_cnt_o    (vec_cnt_o)
  );

  task automatic cmp(input string name, input logic [AW-1:0] actual, input logic [AW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, and record what the skew pipe saw.
  task automatic applyStimulus(input logic e, input logic v, input logic [AW-1:0] d);
    en = e;
    act_valid_i = v;
    act_i = d;
    @(posedge clk);
    #1;
    if (e && rst_n) begin
      histD.push_back(v ? d : '0);
      histV.push_back(v);
    end
  endtask

  // Lane k after the n-th enabled edge carries whatever was presented k enabled edges earlier.
  task automatic checkOutput(input string name);
    logic [AW-1:0] ea;
    logic [PS-1:0] ev;
    logic [AW-1:0] entry;
    int idx;
    ea = '0;
    ev = '0;
    for (int k = 0; k < PS; k++) begin
      idx = histD.size() - 1 - k;
      if (idx >= 0 && histV[idx]) begin
        entry = histD[idx];
        ea[k*DW +: DW] = entry[k*DW +: DW];
        ev[k] = 1'b1;
      end
    end
    cmp({name, "_act"}, act_o, ea);
    cmp({name, "_vld"}, AW'(act_valid_o), AW'(ev));
  endtask

  function automatic logic [AW-1:0] mkVec(input int base, input int step);
    logic [AW-1:0] r;
    r = '0;
    for (int k = 0; k < PS; k++) r[k*DW +: DW] = DW'(base + step * k);
    return r;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] tmpA;
    logic [PS-1:0] tmpV;
    int nAcc;
    logic e;
    logic v;

    for (int i = 0; i < 18; i++) begin
      tmpA = '0;
      tmpV = '0;
      if (i < PS) begin
        tmpA[i*DW +: DW] = DW'(i + 1);
        tmpV[i] = 1'b1;
      end
      tbl[i].e       = 1'b1;
      tbl[i].v       = (i == 0);
      tbl[i].d       = (i == 0) ? mkVec(1, 1) : '0;
      tbl[i].expAct  = tmpA;
      tbl[i].expVld  = tmpV;
      tbl[i].expBusy = (i < 15);
      tbl[i].expDone = (i == 15);
      tbl[i].expCnt  = CW'(1);
    end

    $display("[TB] reset with traffic present");
    en = 1'b1;
    act_valid_i = 1'b1;
    act_i = '1;
    #12;
    cmp("rst_act", act_o, '0);
    cmp("rst_vld", AW'(act_valid_o), '0);
    cmp("rst_busy", AW'(busy_o), '0);
    cmp("rst_done", AW'(drain_done_o), '0);
    cmp("rst_cnt", AW'(vec_cnt_o), '0);
    en = 1'b0;
    act_valid_i = 1'b0;
    act_i = '0;
    rst_n = 1'b1;

    $display("[TB] single vector table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].e, tbl[i].v, tbl[i].d);
      cmp($sformatf("tbl%0d_act", i), act_o, tbl[i].expAct);
      cmp($sformatf("tbl%0d_vld", i), AW'(act_valid_o), AW'(tbl[i].expVld));
      cmp($sformatf("tbl%0d_busy", i), AW'(busy_o), AW'(tbl[i].expBusy));
      cmp($sformatf("tbl%0d_done", i), AW'(drain_done_o), AW'(tbl[i].expDone));
      cmp($sformatf("tbl%0d_cnt", i), AW'(vec_cnt_o), AW'(tbl[i].expCnt));
    end

    $display("[TB] burst of four");
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b1, i < 4, (i < 4) ? mkVec(16 * i, 1) : '0);
      checkOutput($sformatf("burst%0d", i));
      cmp($sformatf("burst%0d_busy", i), AW'(busy_o), AW'(i < 18));
      cmp($sformatf("burst%0d_done", i), AW'(drain_done_o), AW'(i == 18));
      cmp($sformatf("burst%0d_cnt", i), AW'(vec_cnt_o), AW'((i < 4) ? i + 1 : 4));
    end

    $display("[TB] gap re-entry from drain");
    nAcc = 0;
    for (int i = 0; i < 24; i++) begin
      v = (i == 0 || i == 1 || i == 5 || i == 6);
      if (v) nAcc++;
      applyStimulus(1'b1, v, v ? mkVec(8'h80 | (i << 4), 1) : '0);
      checkOutput($sformatf("gap%0d", i));
      cmp($sformatf("gap%0d_busy", i), AW'(busy_o), AW'(i < 21));
      cmp($sformatf("gap%0d_done", i), AW'(drain_done_o), AW'(i == 21));
      cmp($sformatf("gap%0d_cnt", i), AW'(vec_cnt_o), AW'(nAcc));
    end

    $display("[TB] stall during drain with 0xFF on the input");
    for (int i = 0; i < 23; i++) begin
      e = !(i >= 6 && i <= 10);
      v = (i == 0) || !e;
      applyStimulus(e, v, (i == 0) ? mkVec(8'h30, 1) : '1);
      checkOutput($sformatf("stall%0d", i));
      cmp($sformatf("stall%0d_busy", i), AW'(busy_o), AW'(i < 20));
      cmp($sformatf("stall%0d_done", i), AW'(drain_done_o), AW'(i == 20));
      cmp($sformatf("stall%0d_cnt", i), AW'(vec_cnt_o), AW'(1));
    end

    $display("[TB] done pulse held across a stall");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, i == 0, (i == 0) ? mkVec(8'h40, 1) : '0);
    cmp("hold_done_pre", AW'(drain_done_o), AW'(1));
    en = 1'b0;
    #1;
    cmp("hold_done_gated", AW'(drain_done_o), '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    cmp("hold_done_stalled", AW'(drain_done_o), '0);
    cmp("hold_busy", AW'(busy_o), '0);
    en = 1'b1;
    #1;
    cmp("hold_done_resume", AW'(drain_done_o), AW'(1));
    applyStimulus(1'b1, 1'b0, '0);
    cmp("hold_done_after", AW'(drain_done_o), '0);

    $display("[TB] asynchronous reset mid-burst");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, i < 3, (i < 3) ? mkVec(8'h50 + i, 16) : '0);
    cmp("mid_busy_pre", AW'(busy_o), AW'(1));
    #3;
    rst_n = 1'b0;
    #1;
    cmp("mid_act", act_o, '0);
    cmp("mid_vld", AW'(act_valid_o), '0);
    cmp("mid_busy", AW'(busy_o), '0);
    cmp("mid_done", AW'(drain_done_o), '0);
    cmp("mid_cnt", AW'(vec_cnt_o), '0);
    histD.delete();
    histV.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput($sformatf("post%0d", i));
      cmp($sformatf("post%0d_done", i), AW'(drain_done_o), '0);
    end
    applyStimulus(1'b1, 1'b1, mkVec(8'h70, 1));
    checkOutput("restart");
    cmp("restart_cnt", AW'(vec_cnt_o), AW'(1));
    cmp("restart_busy", AW'(busy_o), AW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
